// File: rtl/sound_latch_pkg.sv
// Shared constants for the main-CPU sound latch endpoint: status/control bit positions,
// default command pacing and a status-byte packing helper.
package sound_latch_pkg;

    localparam int unsigned ST_REPLY_PENDING   = 0;
    localparam int unsigned ST_FIFO_FULL       = 1;
    localparam int unsigned ST_FIFO_EMPTY      = 2;
    localparam int unsigned ST_CMD_OVERFLOW    = 3;
    localparam int unsigned ST_REPLY_OVERRUN   = 4;

    localparam int unsigned CTL_FLUSH          = 0;

    localparam int unsigned DEFAULT_GAP_CYCLES = 1024;

    function automatic logic [7:0] pack_status(input logic pending,
                                               input logic full,
                                               input logic empty,
                                               input logic overflow,
                                               input logic overrun);
        logic [7:0] s;
        s                   = '0;
        s[ST_REPLY_PENDING] = pending;
        s[ST_FIFO_FULL]     = full;
        s[ST_FIFO_EMPTY]    = empty;
        s[ST_CMD_OVERFLOW]  = overflow;
        s[ST_REPLY_OVERRUN] = overrun;
        return s;
    endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Synchronous 8-bit command FIFO with flush; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module sound_cmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [7:0]             wdata_i,
    output logic [7:0]             rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          push_ok, pop_ok, wr_en;
    logic [AW-1:0] wr_idx;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    // Flush empties first, so a simultaneous push lands in slot 0.
    assign wr_en  = push_i && (flush_i || push_ok);
    assign wr_idx = flush_i ? '0 : wptr_q[AW-1:0];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = {{AW{1'b0}}, push_i};
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_idx] <= wdata_i;
    end

endmodule

// File: rtl/sound_latch_host.sv
// Main-CPU endpoint of the sound command/reply latch pair. Defining SOUND_CMD_FIFO_EN adds a
// paced command FIFO; otherwise each command write goes straight to the latch next cycle.
module sound_latch_host
    import sound_latch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic       clk_sys_i,
    input  logic       reset_n_i,
    input  logic       cs_i,
    input  logic       cpu_wr_i,
    input  logic       cpu_rd_i,
    input  logic       cpu_a0_i,
    input  logic [7:0] cpu_din_i,
    output logic [7:0] cpu_dout_o,
    output logic       snd_latch_wr_o,
    output logic [7:0] snd_latch_din_o,
    output logic       snd_latch_rd_o,
    input  logic [7:0] snd_reply_i,
    input  logic       snd_reply_rdy_i,
    output logic       irq_o
);

    if (GAP_CYCLES < 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("sound_latch_host: unsupported FIFO_DEPTH/GAP_CYCLES");
    end

    logic cmd_wr, reply_rd, stat_rd;
    assign cmd_wr   = cs_i && cpu_wr_i && !cpu_a0_i;
    assign reply_rd = cs_i && cpu_rd_i && !cpu_a0_i;
    assign stat_rd  = cs_i && cpu_rd_i &&  cpu_a0_i;

    logic       latch_wr_q, latch_wr_d;
    logic [7:0] latch_din_q, latch_din_d;
    logic       fifo_full, fifo_empty;
    logic       overflow_set;

`ifdef SOUND_CMD_FIFO_EN
    localparam int unsigned GapW = $clog2(GAP_CYCLES);

    logic                        ctl_wr, flush, issue;
    logic [7:0]                  fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
    logic [GapW-1:0]             gap_q, gap_d;

    assign ctl_wr = cs_i && cpu_wr_i && cpu_a0_i;
    assign flush  = ctl_wr && cpu_din_i[CTL_FLUSH];
    // A flushed head is discarded rather than sent.
    assign issue  = !fifo_empty && (gap_q == '0) && !flush;
    assign overflow_set = cmd_wr && fifo_full && !issue && !flush;

    sound_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_sys_i),
        .rst_ni  (reset_n_i),
        .push_i  (cmd_wr),
        .pop_i   (issue),
        .flush_i (flush),
        .wdata_i (cpu_din_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    always_comb begin
        gap_d       = gap_q;
        latch_wr_d  = issue;
        latch_din_d = latch_din_q;
        if (issue) begin
            gap_d       = GapW'(GAP_CYCLES - 1);
            latch_din_d = fifo_rdata;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) gap_q <= '0;
        else            gap_q <= gap_d;
    end
`else
    assign fifo_full    = 1'b0;
    assign fifo_empty   = 1'b1;
    assign overflow_set = 1'b0;

    always_comb begin
        latch_wr_d  = cmd_wr;
        latch_din_d = cmd_wr ? cpu_din_i : latch_din_q;
    end
`endif

    // Reply path: capture on a rising edge of the ready level, auto-acknowledge next cycle.
    logic       rdy_prev_q, capture;
    logic [7:0] reply_q, reply_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       overflow_q, overflow_d;
    logic       latch_rd_q;

    assign capture = snd_reply_rdy_i && !rdy_prev_q;

    always_comb begin
        reply_d    = capture ? snd_reply_i : reply_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        overflow_d = overflow_q;
        if (capture)       pending_d = 1'b1;
        else if (reply_rd) pending_d = 1'b0;
        // Sticky bits clear on status read, but a same-cycle set event wins.
        if (stat_rd) begin
            overrun_d  = 1'b0;
            overflow_d = 1'b0;
        end
        if (capture && pending_q && !reply_rd) overrun_d = 1'b1;
        if (overflow_set) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdy_prev_q  <= 1'b0;
            reply_q     <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            overflow_q  <= 1'b0;
            latch_rd_q  <= 1'b0;
            latch_wr_q  <= 1'b0;
            latch_din_q <= '0;
        end else begin
            rdy_prev_q  <= snd_reply_rdy_i;
            reply_q     <= reply_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            overflow_q  <= overflow_d;
            latch_rd_q  <= capture;
            latch_wr_q  <= latch_wr_d;
            latch_din_q <= latch_din_d;
        end
    end

    always_comb begin
        cpu_dout_o = '0;
        if (reply_rd) begin
            cpu_dout_o = reply_q;
        end else if (stat_rd) begin
            cpu_dout_o = pack_status(pending_q, fifo_full, fifo_empty, overflow_q, overrun_q);
        end
    end

    assign snd_latch_wr_o  = latch_wr_q;
    assign snd_latch_din_o = latch_din_q;
    assign snd_latch_rd_o  = latch_rd_q;
    assign irq_o           = pending_q;

endmodule

// File: tb/tb_sound_latch_host.sv
// Randomized scoreboard bench for sound_latch_host; the reference model schedules each
// command pulse by cycle number and tracks reply/status state at transaction level.
module tb_sound_latch_host;

    localparam int unsigned Depth = 4;
    localparam int unsigned Gap   = 16;
`ifdef SOUND_CMD_FIFO_EN
    localparam bit FifoEn = 1'b1;
`else
    localparam bit FifoEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_a0 = 1'b0;
    logic [7:0] cpu_din = '0, cpu_dout;
    logic       snd_latch_wr, snd_latch_rd, irq;
    logic [7:0] snd_latch_din;
    logic [7:0] snd_reply = '0;
    logic       snd_reply_rdy = 1'b0;

    always #5 clk = ~clk;

    sound_latch_host #(
        .FIFO_DEPTH (Depth),
        .GAP_CYCLES (Gap)
    ) dut (
        .clk_sys_i       (clk),
        .reset_n_i       (reset_n),
        .cs_i            (cs),
        .cpu_wr_i        (cpu_wr),
        .cpu_rd_i        (cpu_rd),
        .cpu_a0_i        (cpu_a0),
        .cpu_din_i       (cpu_din),
        .cpu_dout_o      (cpu_dout),
        .snd_latch_wr_o  (snd_latch_wr),
        .snd_latch_din_o (snd_latch_din),
        .snd_latch_rd_o  (snd_latch_rd),
        .snd_reply_i     (snd_reply),
        .snd_reply_rdy_i (snd_reply_rdy),
        .irq_o           (irq)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } cmd_t;

    cmd_t       exp_cmd[$];
    int         sched[$];
    int         exp_lrd[$];
    logic [7:0] exp_rd[$];
    bit         exp_irq[int];

    bit         m_pending = 0, m_overrun = 0, m_overflow = 0, m_prev_rdy = 0;
    logic [7:0] m_reply = '0;
    logic       cur_rdy = 1'b0;
    logic [7:0] cur_rep = '0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual event at cycle %0d required none", name, cyc);
    endtask

    // Bytes still inside the FIFO during cycle t are those whose pulse comes after t.
    function automatic int fifo_count(input int t);
        int n = 0;
        foreach (sched[i]) if (sched[i] > t) n++;
        return n;
    endfunction

    function automatic int last_pulse();
        return (sched.size() > 0) ? sched[$] : -1000000;
    endfunction

    task automatic add_cmd(input logic [7:0] d, input int p);
        cmd_t c;
        c.data = d;
        c.at   = p;
        exp_cmd.push_back(c);
        sched.push_back(p);
    endtask

    task automatic drop_after(input int t);
        while (sched.size() > 0 && sched[$] > t) void'(sched.pop_back());
        while (exp_cmd.size() > 0 && exp_cmd[$].at > t) void'(exp_cmd.pop_back());
    endtask

    // op: 0 idle, 1 command write, 2 control write, 3 reply read, 4 status read
    task automatic step(input int op, input logic [7:0] d, input logic rdy, input logic [7:0] rep);
        int t, cnt, p;
        bit cap, ovr_set, ovf_set;
        @(posedge clk);
        #1;
        t             = cyc;
        cur_rdy       = rdy;
        cur_rep       = rep;
        reset_n       = 1'b1;
        cs            = (op != 0);
        cpu_wr        = (op == 1 || op == 2);
        cpu_rd        = (op == 3 || op == 4);
        cpu_a0        = (op == 2 || op == 4);
        cpu_din       = d;
        snd_reply     = rep;
        snd_reply_rdy = rdy;

        exp_irq[t] = m_pending;
        cnt = FifoEn ? fifo_count(t) : 0;
        if (op == 3) exp_rd.push_back(m_reply);
        if (op == 4) exp_rd.push_back({3'b000, m_overrun, m_overflow, cnt == 0,
                                       cnt == int'(Depth), m_pending});
        cap        = rdy && !m_prev_rdy;
        m_prev_rdy = rdy;
        ovr_set    = 0;
        ovf_set    = 0;

        if (op == 1) begin
            if (!FifoEn) begin
                add_cmd(d, t + 1);
            end else if (fifo_count(t + 1) < int'(Depth)) begin
                p = last_pulse() + int'(Gap);
                if (p < t + 2) p = t + 2;
                add_cmd(d, p);
            end else begin
                ovf_set = 1;
            end
        end
        if (op == 2 && d[0] && FifoEn) drop_after(t);

        if (cap) begin
            if (m_pending && op != 3) ovr_set = 1;
            m_reply   = rep;
            m_pending = 1;
            exp_lrd.push_back(t + 1);
        end else if (op == 3) begin
            m_pending = 0;
        end

        if (op == 4) begin
            m_overrun  = ovr_set;
            m_overflow = ovf_set;
        end else begin
            m_overrun  = m_overrun | ovr_set;
            m_overflow = m_overflow | ovf_set;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 8'h00, cur_rdy, cur_rep);
    endtask

    task automatic reset_pulse();
        int t;
        @(posedge clk);
        #1;
        t             = cyc;
        reset_n       = 1'b0;
        cs            = 1'b0;
        cpu_wr        = 1'b0;
        cpu_rd        = 1'b0;
        snd_reply_rdy = 1'b0;
        cur_rdy       = 1'b0;
        #1;
        check("irq_async_reset", int'(irq), 0);
        check("latch_wr_async_reset", int'(snd_latch_wr), 0);
        check("latch_rd_async_reset", int'(snd_latch_rd), 0);
        exp_irq[t]     = 0;
        exp_irq[t + 1] = 0;
        drop_after(t - 1);
        sched.delete();
        while (exp_lrd.size() > 0 && exp_lrd[$] >= t) void'(exp_lrd.pop_back());
        m_pending  = 0;
        m_overrun  = 0;
        m_overflow = 0;
        m_prev_rdy = 0;
        m_reply    = '0;
        @(posedge clk);
    endtask

    // Monitor: samples mid-cycle and retires scoreboard entries as the DUT presents them.
    initial begin
        cmd_t c;
        int   l;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            if (exp_irq.exists(cyc)) check("irq", int'(irq), int'(exp_irq[cyc]));
            if (snd_latch_wr) begin
                if (exp_cmd.size() == 0) begin
                    unexpected("latch_wr_pulse");
                end else begin
                    c = exp_cmd.pop_front();
                    check("latch_din", int'(snd_latch_din), int'(c.data));
                    check("latch_wr_cycle", cyc, c.at);
                end
            end
            if (snd_latch_rd) begin
                if (exp_lrd.size() == 0) begin
                    unexpected("latch_rd_pulse");
                end else begin
                    l = exp_lrd.pop_front();
                    check("latch_rd_cycle", cyc, l);
                end
            end
            if (cs && cpu_rd) begin
                if (exp_rd.size() == 0) begin
                    unexpected("cpu_read");
                end else begin
                    r = exp_rd.pop_front();
                    check(cpu_a0 ? "status_read" : "reply_read", int'(cpu_dout), int'(r));
                end
            end else begin
                check("dout_idle", int'(cpu_dout), 0);
            end
        end
    end

    initial begin
        int   op;
        logic rdy;
        repeat (3) @(posedge clk);

        step(4, 8'h00, 1'b0, 8'h00);
        step(1, 8'h12, 1'b0, 8'h00);
        step(1, 8'h34, 1'b0, 8'h00);
        step(1, 8'h56, 1'b0, 8'h00);
        idle(60);

        step(1, 8'h9A, 1'b0, 8'h00);
        idle(2);
        for (int i = 0; i < 6; i++) step(1, 8'hC0 + 8'(i), 1'b0, 8'h00);
        step(4, 8'h00, 1'b0, 8'h00);
        step(4, 8'h00, 1'b0, 8'h00);
        idle(100);

        step(0, 8'h00, 1'b1, 8'hA5);
        idle(1);
        step(3, 8'h00, 1'b1, 8'hA5);
        idle(2);
        step(0, 8'h00, 1'b0, 8'h00);

        step(0, 8'h00, 1'b1, 8'h11);
        step(0, 8'h00, 1'b0, 8'h11);
        step(0, 8'h00, 1'b1, 8'h22);
        step(0, 8'h00, 1'b0, 8'h22);
        step(3, 8'h00, 1'b0, 8'h22);
        step(4, 8'h00, 1'b0, 8'h22);

        step(0, 8'h00, 1'b1, 8'h77);
        for (int i = 0; i < 4; i++) step(1, 8'h60 + 8'(i), 1'b1, 8'h77);
        idle(1);
        reset_pulse();
        step(4, 8'h00, 1'b0, 8'h00);
        idle(40);

        rdy = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) reset_pulse();
            if (k == 750) rdy = 1'b0;
            case ($urandom_range(0, 19))
                8, 9, 10, 11: op = 1;
                12:           op = 2;
                13, 14, 15:   op = 3;
                16, 17:       op = 4;
                default:      op = 0;
            endcase
            if ($urandom_range(0, 5) == 0) rdy = ~rdy;
            step(op, 8'($urandom), rdy, 8'($urandom));
        end
        step(0, 8'h00, 1'b0, 8'h00);
        idle(Gap * Depth + 20);

        check("cmd_left", exp_cmd.size(), 0);
        check("latch_rd_left", exp_lrd.size(), 0);
        check("read_left", exp_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
